// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter/rotator: the latched operand moves one bit per BUSY cycle
// under the latched mode. The result register b updates only when DONE is entered.
module seq_shift_unit #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   n,
  output logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_SLL = 3'd0,
    OP_SRL = 3'd1,
    OP_SRA = 3'd2,
    OP_ROL = 3'd3,
    OP_ROR = 3'd4
  } op_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] step;
  logic             mode_illegal;

  assign mode_illegal = (mode > 3'd4);

  // Single-bit move of the work register under the latched mode.
  always_comb begin
    step = work_q;
    case (mode_q)
      OP_SLL:  step = {work_q[WIDTH-2:0], 1'b0};
      OP_SRL:  step = {1'b0, work_q[WIDTH-1:1]};
      OP_SRA:  step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      OP_ROL:  step = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
      OP_ROR:  step = {work_q[0], work_q[WIDTH-1:1]};
      default: step = work_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    b_d     = b_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d = a;
          cnt_d  = n;
          mode_d = mode;
          // Zero shifts and illegal modes complete at once with the operand unchanged.
          if (mode_illegal || (n == '0)) begin
            state_d = DONE;
            b_d     = a;
            err_d   = mode_illegal;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        work_d = step;
        cnt_d  = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d = DONE;
          b_d     = step;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      b_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      b_q     <= b_d;
      err_q   <= err_d;
    end
  end

  assign b    = b_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign err  = err_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Scoreboard bench for seq_shift_unit (WIDTH=8): the stimulus side pushes reference-model
// results with their expected completion cycle; an independent monitor checks each done pulse.
module tb_seq_shift_unit;

  localparam int W = 8;
  localparam int S = 3;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [2:0]   mode;
  logic [W-1:0] a;
  logic [S-1:0] n;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         err;

  seq_shift_unit #(.WIDTH(W), .SHW(S)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .mode (mode),
    .a    (a),
    .n    (n),
    .b    (b),
    .busy (busy),
    .done (done),
    .err  (err)
  );

  typedef struct {
    logic [W-1:0] b;
    logic         err;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc = 0;
  logic [W-1:0] b_prev = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Whole-value reference: shifts and rotations by n, computed in one go.
  function automatic logic [W-1:0] model(input logic [W-1:0] av, input int nv, input logic [2:0] m);
    logic [2*W-1:0] dbl;
    logic [2*W-1:0] sh;
    dbl = {av, av};
    case (m)
      3'd0: return av << nv;
      3'd1: return av >> nv;
      3'd2: return W'($signed(av) >>> nv);
      3'd3: begin sh = dbl << nv; return sh[2*W-1:W]; end
      3'd4: begin sh = dbl >> nv; return sh[W-1:0]; end
      default: return av;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse; also polices b stability and err framing.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'(done), 64'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result_b", 64'(b), 64'(e.b));
          check("result_err", 64'(err), 64'(e.err));
          check("done_cycle", 64'(cyc), 64'(e.cyc));
        end
      end else begin
        if (err) check("err_without_done", 64'(err), 64'(0));
        if (b !== b_prev) check("b_stable", 64'(b), 64'(b_prev));
      end
    end
    b_prev = b;
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (busy !== 1'b0) check("idle_timeout", 64'(busy), 64'(0));
  endtask

  // Issues one operation from IDLE; optional noise scrambles inputs while busy.
  task automatic issue(input logic [W-1:0] av, input int nv, input logic [2:0] m, input bit noise);
    exp_t e;
    int   k;
    wait_idle();
    a = av;
    n = S'(nv);
    mode = m;
    start = 1'b1;
    e.b   = model(av, nv, m);
    e.err = (m > 3'd4);
    e.cyc = cyc + 1 + ((m > 3'd4) ? 0 : nv);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (busy === 1'b1 && k < 50) begin
      if (noise) begin
        start = 1'($urandom);
        a     = W'($urandom);
        n     = S'($urandom);
        mode  = 3'($urandom);
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("drain_empty", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode  = '0;
    a     = '0;
    n     = '0;
    #1;
    check("rst_b", 64'(b), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    issue(8'b10110010, 3, 3'd0, 1'b0);
    issue(8'b10110010, 3, 3'd3, 1'b0);
    issue(8'b10110011, 2, 3'd4, 1'b0);
    issue(8'b10111110, 2, 3'd2, 1'b0);
    issue(8'b10111110, 2, 3'd1, 1'b0);
    issue(8'b11111111, 1, 3'd1, 1'b0);
    issue(8'b10110010, 0, 3'd0, 1'b0);
    issue(8'b10110010, 5, 3'd6, 1'b0);
    issue(8'b01011100, 7, 3'd4, 1'b1);
    issue(8'b10000001, 7, 3'd2, 1'b1);

    // start held through the DONE cycle of a zero-shift op: only one completion.
    wait_idle();
    a = 8'h5A; n = '0; mode = 3'd1; start = 1'b1;
    begin
      exp_t e;
      e.b = 8'h5A; e.err = 1'b0; e.cyc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    a = 8'hC3;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Reset in the middle of BUSY aborts without a done pulse.
    wait_idle();
    a = 8'hF0; n = 3'd6; mode = 3'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    check("abort_b", 64'(b), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    issue(8'b00110101, 4, 3'd3, 1'b0);

    for (int i = 0; i < 60; i++) begin
      issue(W'($urandom), int'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
